nbitrestore: RTL

Bit-serial inverse of the sign-magnitude subtractor: given operand `b`, magnitude `y` and borrow flag `bout`, it reconstructs the original `a`. The rule is `a = b + y` when `bout=0` and `a = b - y` when `bout=1`. It processes one bit per clock, LSB first, through a single full-add/full-subtract cell. It sits downstream of the subtractor in the lab datapath and gives a round-trip check that `a` survives `a → (y, bout) → a`.

---
 rtl/restore_pkg.sv | 12 +
 rtl/nbitrestore_fulladdsub.sv | 24 ++
 rtl/nbitrestore.sv | 113 +++++++++++
 3 files changed

// File: rtl/restore_pkg.sv
// Shared types for the bit-serial restore datapath.
// No logic of its own; state encoding only.
// No flow control.
package restore_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nbitrestore_fulladdsub.sv
// 1-bit full adder / full subtractor cell (sub=1 computes a - b - cin).
// Purely combinational, zero latency.
// No flow control.
module fulladdsub (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic sub,
    output logic s,
    output logic cout
);

    // Inverting the minuend turns the carry equation into the borrow
    // equation: borrow = (~a & b) | (~(a ^ b) & bin).
    logic w_ax;

    // Sum/difference bit and carry/borrow out
    always_comb begin
        w_ax = a ^ sub;
        s    = a ^ b ^ cin;
        cout = (w_ax & b) | (cin & (w_ax ^ b));
    end

endmodule

// File: rtl/nbitrestore.sv
// Reconstructs a = b + y (bout=0) or a = b - y (bout=1), one bit per clock, LSB first.
// Latency: start accepted at edge k, done pulses after edge k+n; one result per n+2 cycles.
// No backpressure: start is sampled only in IDLE and dropped otherwise (no queuing).
module nbitrestore
    import restore_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] b,
    input  logic [n-1:0] y,
    input  logic         bout,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] a,
    output logic         err
);

    // Index must reach n-1 without wrapping; $clog2(n+1) covers n=1 too.
    localparam int IDX_W = $clog2(n + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(n - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [n-1:0]     r_b;
    logic [n-1:0]     r_y;
    logic             r_sub;
    logic             r_c;
    logic [n-1:0]     r_acc;
    logic [n-1:0]     r_a;
    logic             r_err;

    logic             w_s;
    logic             w_cout;
    logic [n-1:0]     w_acc_nxt;

    // Single arithmetic cell, fed from the LSB of the captured shift registers
    fulladdsub u_cell (
        .a    (r_b[0]),
        .b    (r_y[0]),
        .cin  (r_c),
        .sub  (r_sub),
        .s    (w_s),
        .cout (w_cout)
    );

    // Result bit enters the accumulator from the MSB side; after n shifts
    // bit 0 of the result lands in position 0. Written this way so n=1 works.
    always_comb begin
        w_acc_nxt        = r_acc >> 1;
        w_acc_nxt[n-1]   = w_s;
    end

    // FSM, operand capture, serial loop and result hold registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_b     <= '0;
            r_y     <= '0;
            r_sub   <= 1'b0;
            r_c     <= 1'b0;
            r_acc   <= '0;
            r_a     <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_b     <= b;
                        r_y     <= y;
                        r_sub   <= bout;
                        r_c     <= 1'b0;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_b   <= r_b >> 1;
                    r_y   <= r_y >> 1;
                    r_c   <= w_cout;
                    r_acc <= w_acc_nxt;
                    r_idx <= r_idx + IDX_ONE;
                    // Visible result only updates here, so a/err stay stable
                    // while the next conversion is running.
                    if (r_idx == IDX_LAST) begin
                        r_a     <= w_acc_nxt;
                        r_err   <= w_cout;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Status decoded straight from state so reset clears them asynchronously
    always_comb begin
        busy = (r_state == RUN);
        done = (r_state == DONE);
        a    = r_a;
        err  = r_err;
    end

endmodule
